// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor computing D = X - Y, LSB first
// One full-subtractor cell plus a borrow flop; start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] D,
    output logic             B,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateType;

    stateType         state;
    stateType         stateNext;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] rs;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             diffBit;
    logic             borrowNext;
    logic             lastBit;
    logic             accept;
    logic [WIDTH:0]   rsCat;
    logic [WIDTH-1:0] rsNext;

    // Full-subtractor cell on the current LSBs; the concat form keeps WIDTH=1 legal.
    always_comb begin
        diffBit    = xs[0] ^ ys[0] ^ borrow;
        borrowNext = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & borrow);
        rsCat      = {diffBit, rs};
        rsNext     = rsCat[WIDTH:1];
        lastBit    = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (lastBit) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xs     <= '0;
            ys     <= '0;
            rs     <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            D      <= '0;
            B      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (stateNext == RUN);
            done <= (stateNext == DONE);
            if (accept) begin
                xs     <= X;
                ys     <= Y;
                rs     <= '0;
                cnt    <= '0;
                borrow <= 1'b0;
            end else if (state == RUN) begin
                borrow <= borrowNext;
                rs     <= rsNext;
                xs     <= xs >> 1;
                ys     <= ys >> 1;
                cnt    <= cnt + 1'b1;
                // Result registers only move on the final bit so they hold otherwise.
                if (lastBit) begin
                    D <= rsNext;
                    B <= borrowNext;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] X = '0;
    logic [WIDTH-1:0] Y = '0;
    logic [WIDTH-1:0] D;
    logic             B;
    logic             busy;
    logic             done;

    int nChecks = 0;
    int nFail = 0;
    int doneCount = 0;
    bit armed = 0;

    // Schedule-level reference: an accepted start yields (X-Y) mod 16 WIDTH edges later.
    logic [WIDTH-1:0] mD = '0;
    logic             mB = 1'b0;
    logic             mBusy = 1'b0;
    logic             mDone = 1'b0;
    logic [WIDTH-1:0] pendD = '0;
    logic             pendB = 1'b0;
    int               mLeft = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .X    (X),
        .Y    (Y),
        .D    (D),
        .B    (B),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mD    <= '0;
            mB    <= 1'b0;
            mBusy <= 1'b0;
            mDone <= 1'b0;
            mLeft <= 0;
        end else if (mDone) begin
            mDone <= 1'b0;
        end else if (mLeft > 0) begin
            mLeft <= mLeft - 1;
            if (mLeft == 1) begin
                mD    <= pendD;
                mB    <= pendB;
                mDone <= 1'b1;
                mBusy <= 1'b0;
            end
        end else if (start) begin
            pendD <= X - Y;
            pendB <= (X < Y);
            mLeft <= WIDTH;
            mBusy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("D", D, mD);
            check("B", B, mB);
            check("busy", busy, mBusy);
            check("done", done, mDone);
        end
        if (done === 1'b1) doneCount++;
    end

    task automatic checkOut(input string tag, input logic [3:0] expD, input logic expB);
        check({tag, ".D"}, D, expD);
        check({tag, ".B"}, B, expB);
    endtask

    task automatic runOp(input logic [3:0] x, input logic [3:0] y);
        int lat;
        bit seen;
        @(posedge clk); #1;
        X = x;
        Y = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        lat = 0;
        for (int k = 1; k <= WIDTH + 4; k++) begin
            @(negedge clk);
            if (!seen && done === 1'b1) begin
                seen = 1;
                lat = k;
            end
            if (seen) break;
        end
        check("latency", seen ? lat : 0, WIDTH + 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int dc0;
        repeat (2) @(posedge clk);
        armed = 1;
        #1 rst = 1'b0;
        @(negedge clk);
        checkOut("reset", 4'd0, 1'b0);
        check("reset.busy", busy, 1'b0);

        runOp(4'd9, 4'd3);
        checkOut("9-3", 4'd6, 1'b0);
        runOp(4'd3, 4'd9);
        checkOut("3-9", 4'd10, 1'b1);
        runOp(4'd0, 4'd1);
        checkOut("0-1", 4'd15, 1'b1);
        runOp(4'd15, 4'd15);
        checkOut("15-15", 4'd0, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                runOp(a[3:0], b[3:0]);
                check("sweep.D", D, (a - b) & 15);
                check("sweep.B", B, (a < b) ? 1 : 0);
            end
        end

        dc0 = doneCount;
        @(posedge clk); #1;
        X = 4'd12; Y = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; X = 4'd1; Y = 4'd2;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOut("ignore", 4'd7, 1'b0);
        check("ignore.pulses", doneCount - dc0, 1);

        runOp(4'd9, 4'd3);
        checkOut("preload", 4'd6, 1'b0);
        @(posedge clk); #1;
        X = 4'd0; Y = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOut("abort", 4'd0, 1'b0);
        check("abort.busy", busy, 1'b0);
        check("abort.done", done, 1'b0);
        dc0 = doneCount;
        repeat (8) @(posedge clk);
        check("abort.nodone", doneCount - dc0, 0);
        runOp(4'd5, 4'd5);
        checkOut("5-5", 4'd0, 1'b0);

        dc0 = doneCount;
        @(posedge clk); #1;
        start = 1'b1;
        repeat (60) begin
            @(posedge clk); #1;
            X = 4'($urandom);
            Y = 4'($urandom);
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("b2b.pulses", doneCount - dc0, 10);

        repeat (400) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            X = 4'($urandom);
            Y = 4'($urandom);
            rst = ($urandom_range(0, 60) == 0);
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial binary subtractor, the inverse operation to the team's half/full adder blocks. It computes D = X - Y one bit per clock, LSB first, using a half-subtractor/full-subtractor cell and a borrow flip-flop.
- A start/busy/done handshake is used, so it can sit beside the serial adder in the arithmetic test chain.
- The result and borrow register hold until the next operation completes.

Parameters:
- WIDTH, 4, operand and result width in bits (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new subtraction; sampled only in IDLE.
- X  input  WIDTH  minuend; captured on the accepted start edge.
- Y  input  WIDTH  subtrahend; captured on the accepted start edge.
- D  output  WIDTH  difference (X - Y) mod 2^WIDTH, registered.
- B  output  1  final borrow out (1 when X < Y unsigned), registered.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when D/B update.

Behaviour:
- Design: one clock (clk), reset synchronous and active-high (rst). Everything changes only on the rising edge of clk.
- Reset: when rst=1 at an edge, the state goes to IDLE and D, B, busy, done, the internal shift registers, the bit counter and the borrow FF are all cleared to 0. rst has priority over every other input.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge t0:
  - xs<=X, ys<=Y, borrow<=0, cnt<=0, rs<=0.
  - Go to RUN; busy=1 from t0.
- IDLE, start=0: remain in IDLE.
- RUN, each edge:
  - x0=xs[0], y0=ys[0].
  - d = x0^y0^borrow.
  - borrow <= (~x0&y0) | (~(x0^y0)&borrow).
  - rs <= {d, rs[WIDTH-1:1]}; xs, ys shift right by 1; cnt++.
- RUN, edge on which cnt==WIDTH-1 (edge t0+WIDTH), the last bit:
  - D <= final rs value including this bit.
  - B <= new borrow.
  - done<=1, busy<=0, go to DONE.
- DONE: next edge sets done<=0 and goes to IDLE. start is ignored in DONE.
- Latency:
  - start at t0 gives done high between edge t0+WIDTH and edge t0+WIDTH+1.
  - The next start is accepted at t0+WIDTH+2 at the earliest.
  - Throughput is one operation per WIDTH+2 cycles.
- D and B change only at completion. They hold the previous result through RUN and through IDLE indefinitely.
- start asserted in RUN or DONE: ignored entirely, with no queuing. Changes on X and Y during RUN have no effect.
- Arithmetic: D equals the low WIDTH bits of X + ~Y + 1. B equals 1 exactly when X < Y unsigned. X == Y gives D=0, B=0.
- Reset mid-RUN: the operation is aborted, no done pulse is produced, D and B become 0, and the block is ready for start on the next edge.
- cnt width is clog2(WIDTH), or 1 bit when WIDTH=1. WIDTH=1 behaves as a registered half subtractor with latency 1.

Test Plan:
- Reset, then X=9, Y=3, start for 1 cycle:
  - busy high for 4 cycles.
  - done pulses exactly 1 cycle at t0+4.
  - D=4'b0110 (6), B=0.
- X=3, Y=9:
  - D=4'b1010 (10), B=1.
  - Also X=0, Y=1 gives D=15, B=1.
  - Also X=15, Y=15 gives D=0, B=0.
- Exhaustive 16×16 sweep, each run waiting for done: D == (X-Y)&15 and B == (X<Y) for all 256 pairs. D stays stable between done pulses.
- Start X=12, Y=5, then pulse start again with X=1, Y=2 during RUN and during DONE:
  - The second request is ignored.
  - Result D=7, B=0.
  - Only one done pulse occurs.
  - busy is unaffected.
- Load prior result D=6, then start X=0, Y=1 and assert rst at t0+2:
  - Next cycle D=0, B=0, busy=0, done=0.
  - No done pulse follows.
  - A fresh start X=5, Y=5 completes with D=0, B=0.
- Back-to-back: start held high continuously. Operations are accepted every 6 cycles (WIDTH+2), and each produces the correct done pulse and result.
